// File: rtl/uart_tx_string_ctrl_if.sv
// uart_tx_string_ctrl_if: string source and UART handshake bundle for uart_tx_string_ctrl
interface uart_tx_string_ctrl_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W = 6
);
  logic send_enable;
  logic abort;
  logic tx_done;
  logic [8*MAX_LEN-1:0] str;
  logic [LEN_W-1:0] str_len;
  logic [7:0] tx_char;
  logic tx_signal;
  logic busy;
  logic done;
  logic error;
  modport master (
    output send_enable, abort, tx_done, str, str_len,
    input tx_char, tx_signal, busy, done, error
  );
  modport slave (
    input send_enable, abort, tx_done, str, str_len,
    output tx_char, tx_signal, busy, done, error
  );
endinterface

// File: rtl/uart_tx_string_ctrl.sv
// uart_tx_string_ctrl: latches a string and feeds it byte by byte to a UART frame transmitter
module uart_tx_string_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W = 6,
  parameter int EOL_MODE = 0,
  parameter int TIMEOUT_CYC = 200_000
) (
  input logic clk,
  input logic reset_p,
  uart_tx_string_ctrl_if.slave bus
);
  localparam int IW = LEN_W + 1;
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [IW-1:0] EOL_N = IW'(EOL_MODE == 0 ? 0 : EOL_MODE == 1 ? 1 : 2);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;
  state_t state, state_d;
  logic [8*MAX_LEN-1:0] str_q, str_d;
  logic [IW-1:0] len_q, len_d, tot_q, tot_d, idx, idx_d, pos, len_in;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0] char_q, char_d, body, trail;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  assign len_in = {1'b0, bus.str_len > MAX_L ? MAX_L : bus.str_len};
  assign pos = len_q - idx - IW'(1);
  assign body = str_q[{pos, 3'b000} +: 8];
  assign trail = (EOL_MODE == 2 && idx == len_q) ? 8'h0D : 8'h0A;
  assign bus.tx_char = char_q;
  assign bus.tx_signal = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.error = err_q;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state <= IDLE;
      str_q <= '0;
      len_q <= '0;
      tot_q <= '0;
      idx <= '0;
      cnt <= '0;
      char_q <= '0;
      tx_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      str_q <= str_d;
      len_q <= len_d;
      tot_q <= tot_d;
      idx <= idx_d;
      cnt <= cnt_d;
      char_q <= char_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // next state: abort beats timeout, timeout beats tx_done
  always_comb begin
    state_d = state;
    str_d = str_q;
    len_d = len_q;
    tot_d = tot_q;
    idx_d = idx;
    cnt_d = cnt;
    char_d = char_q;
    tx_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state != IDLE && bus.abort) begin
      state_d = IDLE;
      busy_d = 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.send_enable) begin
          str_d = bus.str;
          len_d = len_in;
          tot_d = len_in + EOL_N;
          idx_d = '0;
          cnt_d = '0;
          busy_d = 1'b1;
          state_d = (len_in + EOL_N) == '0 ? FIN : SEND;
        end
        SEND: begin
          char_d = idx < len_q ? body : trail;
          tx_d = 1'b1;
          idx_d = idx + IW'(1);
          cnt_d = '0;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d = cnt + CW'(1);
          if (TIMEOUT_CYC != 0 && cnt == TMO_LAST) begin
            err_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
          end else if (bus.tx_done)
            state_d = idx < tot_q ? SEND : FIN;
        end
        FIN: begin
          done_d = 1'b1;
          busy_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_string_ctrl.sv
// tb_uart_tx_string_ctrl: drives two controllers (no trailer / CR+LF trailer) with shared stimulus
module tb_uart_tx_string_ctrl;
  localparam int ML = 8, LW = 4, TMO = 100;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, reset_p = 1, send_en = 0, abort = 0, force_done = 0, resp_en = 1;
  logic pulse_a = 0, pulse_b = 0;
  logic [8*ML-1:0] str = '0;
  logic [LW-1:0] str_len = '0;
  int cyc = 0, checks = 0, errors = 0, resp_dly = 5, set_a = 0, set_b = 0;
  int n_done[2] = '{0, 0}, n_err[2] = '{0, 0}, done_cyc[2] = '{0, 0}, err_cyc[2] = '{0, 0};
  bq_t got_a, got_b;
  int tx_cyc_a[$], tx_cyc_b[$];
  uart_tx_string_ctrl_if #(.MAX_LEN(ML), .LEN_W(LW)) ifa ();
  uart_tx_string_ctrl_if #(.MAX_LEN(ML), .LEN_W(LW)) ifb ();
  uart_tx_string_ctrl #(.MAX_LEN(ML), .LEN_W(LW), .EOL_MODE(0), .TIMEOUT_CYC(TMO))
    dut_a (.clk(clk), .reset_p(reset_p), .bus(ifa.slave));
  uart_tx_string_ctrl #(.MAX_LEN(ML), .LEN_W(LW), .EOL_MODE(2), .TIMEOUT_CYC(TMO))
    dut_b (.clk(clk), .reset_p(reset_p), .bus(ifb.slave));
  assign ifa.send_enable = send_en;
  assign ifb.send_enable = send_en;
  assign ifa.abort = abort;
  assign ifb.abort = abort;
  assign ifa.str = str;
  assign ifb.str = str;
  assign ifa.str_len = str_len;
  assign ifb.str_len = str_len;
  assign ifa.tx_done = pulse_a | force_done;
  assign ifb.tx_done = pulse_b | force_done;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ifa.tx_signal) begin got_a.push_back(ifa.tx_char); tx_cyc_a.push_back(cyc); end
    if (ifb.tx_signal) begin got_b.push_back(ifb.tx_char); tx_cyc_b.push_back(cyc); end
    if (ifa.done) begin n_done[0] <= n_done[0] + 1; done_cyc[0] <= cyc; end
    if (ifb.done) begin n_done[1] <= n_done[1] + 1; done_cyc[1] <= cyc; end
    if (ifa.error) begin n_err[0] <= n_err[0] + 1; err_cyc[0] <= cyc; end
    if (ifb.error) begin n_err[1] <= n_err[1] + 1; err_cyc[1] <= cyc; end
  end
  initial forever begin
    @(negedge clk);
    if (ifa.tx_signal && resp_en) begin
      repeat (resp_dly) @(negedge clk);
      pulse_a = 1; set_a = cyc;
      @(negedge clk);
      pulse_a = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (ifb.tx_signal && resp_en) begin
      repeat (resp_dly) @(negedge clk);
      pulse_b = 1; set_b = cyc;
      @(negedge clk);
      pulse_b = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [8*ML-1:0] s, input int l, output int k);
    @(negedge clk);
    str = s; str_len = LW'(l); send_en = 1; k = cyc;
    @(negedge clk);
    send_en = 0; str = {$urandom, $urandom}; str_len = LW'($urandom);
  endtask
  task automatic wait_tx(input int ba, input int n);
    int t = 0;
    while (got_a.size() - ba < n && t < 500) begin @(negedge clk); t++; end
    chk("wait_tx", t < 500, 1);
  endtask
  task automatic run(input logic [8*ML-1:0] s, input int l, input bit dup);
    bq_t ea, eb;
    int n, ba, bb, da, db, ra, rb, k, t;
    n = l > ML ? ML : l;
    for (int j = 0; j < n; j++) ea.push_back(s[8*(n-1-j) +: 8]);
    eb = ea; eb.push_back(8'h0D); eb.push_back(8'h0A);
    ba = got_a.size(); bb = got_b.size();
    da = n_done[0]; db = n_done[1]; ra = n_err[0]; rb = n_err[1];
    start(s, l, k);
    if (dup && ea.size() >= 2) begin
      wait_tx(ba, 1);
      send_en = 1;
      @(negedge clk);
      send_en = 0;
    end
    t = 0;
    while ((ifa.busy || ifb.busy) && t < 3000) begin @(negedge clk); t++; end
    chk("busy_bound", t < 3000, 1);
    repeat (3) @(negedge clk);
    chk("count_a", got_a.size() - ba, ea.size());
    chk("count_b", got_b.size() - bb, eb.size());
    for (int j = 0; j < ea.size() && ba + j < got_a.size(); j++) chk("char_a", got_a[ba+j], ea[j]);
    for (int j = 0; j < eb.size() && bb + j < got_b.size(); j++) chk("char_b", got_b[bb+j], eb[j]);
    chk("done_a", n_done[0] - da, 1);
    chk("done_b", n_done[1] - db, 1);
    chk("err_a", n_err[0] - ra, 0);
    chk("err_b", n_err[1] - rb, 0);
    if (ea.size() > 0 && got_a.size() > ba) begin
      chk("lat_a", tx_cyc_a[ba], k + 2);
      chk("done_lat_a", done_cyc[0], set_a + 2);
    end else chk("done_empty_a", done_cyc[0], k + 2);
    if (got_b.size() > bb) chk("lat_b", tx_cyc_b[bb], k + 2);
    chk("done_lat_b", done_cyc[1], set_b + 2);
  endtask
  initial begin
    int k, ba, bb, da, db, ra, rb, t;
    logic [8*ML-1:0] s;
    repeat (3) @(negedge clk);
    chk("rst_a", {ifa.tx_char, ifa.tx_signal, ifa.busy, ifa.done, ifa.error}, 0);
    chk("rst_b", {ifb.tx_char, ifb.tx_signal, ifb.busy, ifb.done, ifb.error}, 0);
    reset_p = 0;
    resp_dly = 5;
    run(64'h414243, 3, 0);
    run(64'h4849, 2, 0);
    run({$urandom, $urandom}, 0, 0);
    run({$urandom, $urandom}, 12, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    run(64'h0102030405060708, 8, 1);
    for (int r = 0; r < 10; r++) begin
      resp_dly = $urandom_range(0, 6);
      run({$urandom, $urandom}, $urandom_range(0, 11), 1'($urandom_range(0, 1)));
    end
    resp_en = 0;
    s = {$urandom, $urandom};
    ba = got_a.size(); bb = got_b.size(); da = n_done[0]; db = n_done[1];
    ra = n_err[0]; rb = n_err[1];
    start(s, 3, k);
    t = 0;
    while ((n_err[0] == ra || n_err[1] == rb) && t < 300) begin @(negedge clk); t++; end
    chk("tmo_bound", t < 300, 1);
    @(negedge clk);
    chk("tmo_err_a", n_err[0] - ra, 1);
    chk("tmo_err_b", n_err[1] - rb, 1);
    chk("tmo_cyc_a", err_cyc[0], k + 2 + TMO);
    chk("tmo_cyc_b", err_cyc[1], k + 2 + TMO);
    chk("tmo_busy", {ifa.busy, ifb.busy}, 0);
    chk("tmo_tx_a", got_a.size() - ba, 1);
    chk("tmo_done", (n_done[0] - da) + (n_done[1] - db), 0);
    resp_en = 1;
    resp_dly = 2;
    run(s, 3, 0);
    resp_dly = 4;
    ba = got_a.size(); bb = got_b.size(); da = n_done[0]; db = n_done[1];
    ra = n_err[0]; rb = n_err[1];
    start({$urandom, $urandom}, 5, k);
    wait_tx(ba, 2);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", {ifa.busy, ifb.busy}, 0);
    chk("abort_char", ifa.tx_char, got_a[got_a.size()-1]);
    repeat (20) @(negedge clk);
    chk("abort_tx_a", got_a.size() - ba, 2);
    chk("abort_tx_b", got_b.size() - bb, 2);
    chk("abort_done", (n_done[0] - da) + (n_done[1] - db), 0);
    chk("abort_err", (n_err[0] - ra) + (n_err[1] - rb), 0);
    resp_en = 0;
    ba = got_a.size(); da = n_done[0]; ra = n_err[0];
    start({$urandom, $urandom}, 3, k);
    wait_tx(ba, 1);
    reset_p = 1;
    @(negedge clk);
    reset_p = 0;
    chk("wrst_a", {ifa.tx_char, ifa.tx_signal, ifa.busy, ifa.done, ifa.error}, 0);
    chk("wrst_b", {ifb.tx_char, ifb.tx_signal, ifb.busy, ifb.done, ifb.error}, 0);
    repeat (5) @(negedge clk);
    chk("wrst_quiet", (n_done[0] - da) + (n_err[0] - ra), 0);
    ba = got_a.size(); bb = got_b.size(); da = n_done[0]; ra = n_err[0];
    start({$urandom, $urandom}, 4, k);
    wait_tx(ba, 1);
    force_done = 1; abort = 1;
    @(negedge clk);
    force_done = 0; abort = 0;
    chk("sim_busy", {ifa.busy, ifb.busy}, 0);
    repeat (20) @(negedge clk);
    chk("sim_tx_a", got_a.size() - ba, 1);
    chk("sim_tx_b", got_b.size() - bb, 1);
    chk("sim_quiet", (n_done[0] - da) + (n_err[0] - ra), 0);
    resp_en = 1;
    resp_dly = 1;
    run(64'h5a5b5c, 3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
